instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/fetch_pkg.sv | 16 +
 rtl/return_stack.sv | 64 ++++++
 rtl/instruction_fetch.sv | 112 +++++++++++
 tb/tb_instruction_fetch.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, defaults and redirect-source encoding for the fetch unit
package fetch_pkg;
   localparam int ADDR_W            = 12;
   localparam int INSTR_W           = 19;
   localparam int RAS_DEPTH_DEFAULT = 4;

   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [INSTR_W-1:0] instr_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_REDIRECT,
      SRC_RET,
      SRC_CALL
   } redir_src_e;
endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - circular return-address stack; a push when full overwrites the oldest entry
module return_stack
   import fetch_pkg::*;
#(
   parameter int DEPTH = RAS_DEPTH_DEFAULT
) (
   input  logic  clock,
   input  logic  reset_n,
   input  logic  push,
   input  logic  pop,
   input  addr_t push_data,
   output addr_t top,
   output logic  empty,
   output logic  full
);
   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int               CNT_W    = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   addr_t            entries_q [DEPTH];
   addr_t            entries_d [DEPTH];
   logic [PTR_W-1:0] sp_q, sp_d, sp_inc, sp_dec;
   logic [CNT_W-1:0] count_q, count_d;

   // sp_q points at the slot the next push writes; the top lives one below it
   always_comb begin
      sp_inc = (sp_q == LAST) ? '0 : sp_q + 1'b1;
      sp_dec = (sp_q == '0) ? LAST : sp_q - 1'b1;
      empty  = (count_q == '0);
      full   = (count_q == FULL_CNT);
      top    = entries_q[sp_dec];
   end

   always_comb begin
      entries_d = entries_q;
      sp_d      = sp_q;
      count_d   = count_q;
      if (push) begin
         entries_d[sp_q] = push_data;
         sp_d            = sp_inc;
         if (!full) begin
            count_d = count_q + 1'b1;
         end
      end else if (pop && !empty) begin
         sp_d    = sp_dec;
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         sp_q    <= '0;
         count_q <= '0;
      end else begin
         entries_q <= entries_d;
         sp_q      <= sp_d;
         count_q   <= count_d;
      end
   end
endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - zero-bubble fetch stage with redirect/call/return steering and a return stack
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter addr_t RESET_PC  = 12'd0,
   parameter int    RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
   input  logic   clock,
   input  logic   reset_n,
   input  logic   stall,
   input  logic   redirect_valid,
   input  addr_t  redirect_target,
   input  logic   call_valid,
   input  addr_t  call_target,
   input  logic   ret_valid,
   output addr_t  imem_address,
   input  instr_t imem_instruction,
   output instr_t instruction,
   output addr_t  instruction_pc,
   output logic   instruction_valid,
   output logic   ras_underflow
);
   redir_src_e src;
   addr_t      target, ret_addr, ras_top;
   addr_t      pc_q, pc_d, ipc_q, ipc_d;
   logic       valid_q, valid_d, uf_q, uf_d;
   logic       push, pop, ras_empty, ras_full_unused;

   always_comb begin
      src = SRC_NONE;
      if (redirect_valid) begin
         src = SRC_REDIRECT;
      end else if (ret_valid) begin
         src = SRC_RET;
      end else if (call_valid) begin
         src = SRC_CALL;
      end
   end

   assign ret_addr = ipc_q + 1'b1;

   always_comb begin
      target = RESET_PC;
      push   = 1'b0;
      pop    = 1'b0;
      uf_d   = 1'b0;
      case (src)
         SRC_REDIRECT: target = redirect_target;
         SRC_RET: begin
            pop = 1'b1;
            if (ras_empty) begin
               uf_d = 1'b1;
            end else begin
               target = ras_top;
            end
         end
         SRC_CALL: begin
            push   = 1'b1;
            target = call_target;
         end
         default: ;
      endcase

      // A redirect acts even under stall; a plain stall re-reads the presented address
      pc_d         = pc_q;
      ipc_d        = ipc_q;
      valid_d      = valid_q;
      imem_address = pc_q;
      if (src != SRC_NONE) begin
         imem_address = target;
         ipc_d        = target;
         pc_d         = target + 1'b1;
         valid_d      = 1'b1;
      end else if (stall) begin
         imem_address = ipc_q;
      end else begin
         ipc_d   = pc_q;
         pc_d    = pc_q + 1'b1;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q    <= RESET_PC;
         ipc_q   <= '0;
         valid_q <= 1'b0;
         uf_q    <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
         uf_q    <= uf_d;
      end
   end

   return_stack #(.DEPTH(RAS_DEPTH)) u_ras (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (push),
      .pop       (pop),
      .push_data (ret_addr),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full_unused)
   );

   assign instruction       = imem_instruction;
   assign instruction_pc    = ipc_q;
   assign instruction_valid = valid_q & ~(redirect_valid | ret_valid | call_valid);
   assign ras_underflow     = uf_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch against a behavioural fetch model
module tb_instruction_fetch;
   localparam logic [11:0] RESET_PC  = 12'd0;
   localparam int          RAS_DEPTH = 4;

   typedef struct {
      logic [11:0] ipc;
      logic        valid;
      logic        uf;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        stall, redirect_valid, call_valid, ret_valid;
   logic [11:0] redirect_target, call_target;
   logic [11:0] imem_address, instruction_pc;
   logic [18:0] imem_q, instruction;
   logic        instruction_valid, ras_underflow;

   int          n_cmp = 0;
   int          n_err = 0;
   exp_t        sb[$];
   logic [11:0] m_stack[$];
   logic [11:0] m_pc, m_ipc;
   logic        m_valid;

   always #5 clock = ~clock;

   // instruction memory: mem[a] = 0x100 + a, registered read
   always @(posedge clock) imem_q <= 19'h100 + 19'(imem_address);

   instruction_fetch #(.RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH)) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .stall             (stall),
      .redirect_valid    (redirect_valid),
      .redirect_target   (redirect_target),
      .call_valid        (call_valid),
      .call_target       (call_target),
      .ret_valid         (ret_valid),
      .imem_address      (imem_address),
      .imem_instruction  (imem_q),
      .instruction       (instruction),
      .instruction_pc    (instruction_pc),
      .instruction_valid (instruction_valid),
      .ras_underflow     (ras_underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_stack.delete();
      m_pc    = RESET_PC;
      m_ipc   = 12'd0;
      m_valid = 1'b0;
      sb.push_back('{ipc: 12'd0, valid: 1'b0, uf: 1'b0});
   endtask

   // Called at a negedge: drive, check the presented state, advance the model, wait one clock.
   task automatic cycle(input logic st, input logic rv, input logic [11:0] rt,
                        input logic cv, input logic [11:0] ct, input logic retv);
      exp_t        e;
      logic        any, uf;
      logic [11:0] tgt, exp_addr;
      stall = st; redirect_valid = rv; redirect_target = rt;
      call_valid = cv; call_target = ct; ret_valid = retv;
      #1;
      any = rv | cv | retv;
      if (sb.size() == 0) begin
         chk("sb_underrun", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk("valid", 32'(instruction_valid), 32'(e.valid && !any));
         chk("instruction_pc", 32'(instruction_pc), 32'(e.ipc));
         if (e.valid) chk("instruction", 32'(instruction), 32'h100 + 32'(e.ipc));
         chk("ras_underflow", 32'(ras_underflow), 32'(e.uf));
      end
      uf  = 1'b0;
      tgt = RESET_PC;
      if (rv) begin
         tgt = rt;
      end else if (retv) begin
         if (m_stack.size() == 0) uf = 1'b1;
         else tgt = m_stack.pop_back();
      end else if (cv) begin
         if (m_stack.size() == RAS_DEPTH) void'(m_stack.pop_front());
         m_stack.push_back(m_ipc + 12'd1);
         tgt = ct;
      end
      exp_addr = any ? tgt : (st ? m_ipc : m_pc);
      chk("imem_address", 32'(imem_address), 32'(exp_addr));
      if (any) begin
         m_ipc = tgt; m_pc = tgt + 12'd1; m_valid = 1'b1;
      end else if (!st) begin
         m_ipc = m_pc; m_pc = m_pc + 12'd1; m_valid = 1'b1;
      end
      sb.push_back('{ipc: m_ipc, valid: m_valid, uf: uf});
      @(negedge clock);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0);
   endtask

   task automatic run_to(input logic [11:0] a);
      int n = 0;
      while (!(m_ipc == a && m_valid) && n < 5000) begin
         idle();
         n++;
      end
      chk("run_to", 32'(instruction_pc), 32'(a));
   endtask

   task automatic reset_mid_stall();
      stall = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_valid", 32'(instruction_valid), 32'd0);
      chk("rst_async_pc", 32'(instruction_pc), 32'd0);
      chk("rst_async_uf", 32'(ras_underflow), 32'd0);
      chk("rst_async_imem", 32'(imem_address), 32'(RESET_PC));
      stall = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      stall = 1'b0; redirect_valid = 1'b0; call_valid = 1'b0; ret_valid = 1'b0;
      redirect_target = '0; call_target = '0;
      repeat (2) @(negedge clock);
      chk("reset_valid", 32'(instruction_valid), 32'd0);
      chk("reset_pc", 32'(instruction_pc), 32'd0);
      chk("reset_imem", 32'(imem_address), 32'(RESET_PC));
      chk("reset_uf", 32'(ras_underflow), 32'd0);
      reset_n = 1'b1;
      model_reset();

      repeat (5) idle();
      run_to(12'd2);
      repeat (3) cycle(1'b1, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0);
      repeat (3) idle();

      run_to(12'd5);
      cycle(1'b0, 1'b1, 12'd40, 1'b0, 12'd0, 1'b0);
      chk("redirect_pc40", 32'(instruction_pc), 32'd40);
      chk("redirect_instr", 32'(instruction), 32'h128);
      repeat (2) idle();
      cycle(1'b1, 1'b1, 12'd40, 1'b0, 12'd0, 1'b0);
      repeat (2) idle();

      cycle(1'b0, 1'b1, 12'd8, 1'b0, 12'd0, 1'b0);
      run_to(12'd10);
      cycle(1'b0, 1'b0, 12'd0, 1'b1, 12'd200, 1'b0);
      run_to(12'd202);
      cycle(1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b1);
      chk("ret_to_11", 32'(instruction_pc), 32'd11);
      repeat (2) idle();

      reset_mid_stall();
      repeat (3) idle();
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 1'b0, 12'd0, 1'b1, 12'(300 + 16 * k), 1'b0);
         idle();
      end
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b1);
         idle();
      end

      cycle(1'b0, 1'b0, 12'd0, 1'b1, 12'd500, 1'b0);
      idle();
      cycle(1'b0, 1'b1, 12'd60, 1'b0, 12'd0, 1'b1);
      chk("redir_beats_ret", 32'(instruction_pc), 32'd60);
      idle();
      cycle(1'b0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b1);
      repeat (2) idle();

      cycle(1'b0, 1'b1, 12'd4092, 1'b0, 12'd0, 1'b0);
      run_to(12'd4094);
      repeat (4) idle();

      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 15);
         cycle(r inside {3, 4, 5}, r == 0 || r == 6, 12'($urandom),
               r == 2 || r == 6 || r == 7, 12'($urandom), r == 1 || r == 6 || r == 7);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
